// File: rtl/demux1x2_valvulas.sv
// -----------------------------------------------------------------------------
// demux1x2_valvulas
//
// Purpose:
//   Sequential 1-to-2 demultiplexer for the irrigation valve path. A single
//   valve-open request is routed to the sprinkler (out0) or drip (out1) driver
//   according to selector S. Break-before-make is enforced: after any output
//   turn-off both drives stay low for DEAD_CYCLES clock cycles, so the two
//   valves are never energised together.
//
// Parameters:
//   DEAD_CYCLES  dead time in clock cycles after any turn-off (legal 1..255)
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   in         in   valve-open request (1 = water requested)
//   S          in   selector: 0 -> out0, 1 -> out1
//   out0       out  sprinkler valve drive (registered)
//   out1       out  drip valve drive (registered)
//   busy       out  dead time running (registered)
//   sel_ativo  out  selector latched at the last entry into an ON state
//   trocas     out  8-bit saturating count of ON-state entries
//                   (present only when DEMUX_CONTADOR_EN is defined)
//
// Configuration macro:
//   DEMUX_CONTADOR_EN  enables the trocas port and its counter register.
// -----------------------------------------------------------------------------
module demux1x2_valvulas #(
  parameter int unsigned DEAD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in,
  input  logic       S,
  output logic       out0,
  output logic       out1,
  output logic       busy,
  output logic       sel_ativo
`ifdef DEMUX_CONTADOR_EN
  ,
  output logic [7:0] trocas
`endif
);

  localparam logic [7:0] DEAD_LOAD = 8'(DEAD_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON0  = 2'd1,
    ST_ON1  = 2'd2,
    ST_DEAD = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       sel_q, sel_d;
  logic       out0_q, out1_q, busy_q;
  logic       enter_on;

  // Next-state logic.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in) begin
          state_d = S ? ST_ON1 : ST_ON0;
          sel_d   = S;
        end
      end

      ST_ON0: begin
        // A simultaneous request drop and selector change is one DEAD entry.
        if (!in || S) begin
          state_d = ST_DEAD;
          cnt_d   = DEAD_LOAD;
        end
      end

      ST_ON1: begin
        if (!in || !S) begin
          state_d = ST_DEAD;
          cnt_d   = DEAD_LOAD;
        end
      end

      ST_DEAD: begin
        cnt_d = cnt_q - 8'd1;
        // Inputs are only looked at on the exit edge; mid-DEAD activity is
        // ignored and cannot restart the count. The <= also covers a zero
        // load so the state can never get stuck.
        if (cnt_q <= 8'd1) begin
          cnt_d = 8'd0;
          if (in) begin
            state_d = S ? ST_ON1 : ST_ON0;
            sel_d   = S;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // ON states are only ever entered from IDLE or DEAD.
  assign enter_on = ((state_q == ST_IDLE) || (state_q == ST_DEAD)) &&
                    ((state_d == ST_ON0)  || (state_d == ST_ON1));

  // Outputs are decoded from the next state and registered, so each drive
  // changes on the same edge as the state and is glitch-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      sel_q   <= 1'b0;
      out0_q  <= 1'b0;
      out1_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      out0_q  <= (state_d == ST_ON0);
      out1_q  <= (state_d == ST_ON1);
      busy_q  <= (state_d == ST_DEAD);
    end
  end

  assign out0      = out0_q;
  assign out1      = out1_q;
  assign busy      = busy_q;
  assign sel_ativo = sel_q;

`ifdef DEMUX_CONTADOR_EN
  logic [7:0] trocas_q;

  // Saturating entry counter; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trocas_q <= 8'd0;
    end else if (enter_on && (trocas_q != 8'hFF)) begin
      trocas_q <= trocas_q + 8'd1;
    end
  end

  assign trocas = trocas_q;
`else
  logic unused_enter_on;
  assign unused_enter_on = enter_on;
`endif

endmodule
